// File: rtl/noc_vc_link_buffer.sv
// Inter-router link stage: two VC FIFOs (even/odd) drained into one registered
// output in polarity order, with saturating per-VC delivery counters.

module noc_vc_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0]  occ_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [AW:0]       occ_q, occ_d;

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_comb begin
    occ_d = occ_q;
    if (push_i && !pop_i) occ_d = occ_q + (AW+1)'(1);
    else if (!push_i && pop_i) occ_d = occ_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i)  rp_q <= rp_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  assign rdata_o = mem_q[rp_q];
  assign occ_o   = occ_q;
endmodule

module noc_vc_link_buffer #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 4,
  parameter int VC_BIT     = 63,
  parameter int STRICT_POL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   si,
  input  logic [DATA_W-1:0]      packet_in,
  output logic                   ri,
  output logic                   so,
  output logic [DATA_W-1:0]      packet_out,
  input  logic                   ro,
  output logic                   polarity,
  output logic [$clog2(DEPTH):0] occ_even,
  output logic [$clog2(DEPTH):0] occ_odd,
  output logic [CNT_W-1:0]       cnt_even,
  output logic [CNT_W-1:0]       cnt_odd,
  input  logic                   clr_cnt
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [1:0]             push, pop, nempty;
  logic [1:0][DATA_W-1:0] head;
  logic [1:0][OW-1:0]     occ;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                   pol_q, so_q;
  logic [DATA_W-1:0]      pout_q;
  logic                   vc_in, vc_out, xfer, free, sel, load;

  assign vc_in  = packet_in[VC_BIT];
  assign vc_out = pout_q[VC_BIT];
  // Full is judged on pre-edge occupancy: a pop on the same edge never frees a slot.
  assign ri     = (occ[vc_in] != OW'(DEPTH));
  assign xfer   = so_q & ro;
  assign free   = ~so_q | ro;
  assign sel    = (STRICT_POL != 0) ? pol_q : (nempty[pol_q] ? pol_q : ~pol_q);
  assign load   = free & nempty[sel];

  for (genvar v = 0; v < 2; v++) begin : g_vc
    assign nempty[v] = |occ[v];
    assign push[v]   = si & ri & (vc_in == 1'(v));
    assign pop[v]    = load & (sel == 1'(v));

    noc_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[v]),
      .pop_i   (pop[v]),
      .wdata_i (packet_in),
      .rdata_o (head[v]),
      .occ_o   (occ[v])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) cnt_d = '0;
    else if (xfer && !(&cnt_q[vc_out])) cnt_d[vc_out] = cnt_q[vc_out] + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pol_q  <= 1'b0;
      so_q   <= 1'b0;
      pout_q <= '0;
      cnt_q  <= '0;
    end else begin
      pol_q <= ~pol_q;
      cnt_q <= cnt_d;
      if (load) begin
        pout_q <= head[sel];
        so_q   <= 1'b1;
      end else if (xfer) begin
        so_q   <= 1'b0;
      end
    end
  end

  assign so         = so_q;
  assign packet_out = pout_q;
  assign polarity   = pol_q;
  assign occ_even   = occ[0];
  assign occ_odd    = occ[1];
  assign cnt_even   = cnt_q[0];
  assign cnt_odd    = cnt_q[1];
endmodule
